// File: rtl/ty_ctrl_pkg.sv
// Shared state encoding, default widths and length type for the TyBEC
// stream run controller and its beat counters.
package ty_ctrl_pkg;

   localparam int TY_LENW = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } run_state_t;

   typedef logic [TY_LENW-1:0] run_len_t;

endpackage

// File: rtl/ty_beat_counter.sv
// Saturating beat counter; o_hit_next flags that the next increment lands
// exactly on the run limit, which drives tlast and the FSM exits.
module ty_beat_counter
   import ty_ctrl_pkg::*;
#(
   parameter int W = TY_LENW
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_limit,
   output logic [W-1:0] o_count,
   output logic         o_hit_next
);

   logic [W-1:0] r_count;

   // Holds at the limit so a stray beat can never wrap the count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != i_limit)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count    = r_count;
   assign o_hit_next = (r_count == (i_limit - W'(1)));

endmodule

// File: rtl/ty_stream_run_ctrl.sv
// Run controller between the shell's AXI-stream channels and the TyBEC
// kernel: joins input handshakes, counts beats, marks tlast, pulses done.
module ty_stream_run_ctrl
   import ty_ctrl_pkg::*;
#(
   parameter int C_NUM_CHANNELS = 2,
   parameter int LENW           = TY_LENW
) (
   input  logic                      aclk,
   input  logic                      areset_n,
   input  logic                      start,
   input  logic [LENW-1:0]           len,
   output logic                      busy,
   output logic                      done,
   output logic                      err_extra,
   output logic [LENW-1:0]           in_cnt,
   output logic [LENW-1:0]           out_cnt,
   input  logic [C_NUM_CHANNELS-1:0] s_tvalid,
   output logic [C_NUM_CHANNELS-1:0] s_tready,
   output logic                      k_ivalid,
   input  logic                      k_iready,
   input  logic                      k_ovalid,
   output logic                      k_oready,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast
);

   run_state_t      r_state;
   logic [LENW-1:0] r_len_q;
   logic            r_done;
   logic            r_err_extra;

   logic            w_start_ok;
   logic            w_in_act;
   logic            w_out_act;
   logic            w_in_beat;
   logic            w_out_beat;
   logic            w_in_last;
   logic            w_out_last;
   logic [LENW-1:0] w_in_cnt;
   logic [LENW-1:0] w_out_cnt;

   assign w_start_ok = (r_state == IDLE) && start;
   assign w_in_act   = (r_state == RUN);
   assign w_out_act  = (r_state == RUN) || (r_state == DRAIN);

   // Handshakes pass straight through, gated only by the registered state.
   assign k_ivalid   = w_in_act && (&s_tvalid) && (w_in_cnt < r_len_q);
   assign w_in_beat  = k_ivalid && k_iready;
   assign s_tready   = {C_NUM_CHANNELS{w_in_beat}};

   assign m_tvalid   = w_out_act && k_ovalid;
   assign k_oready   = w_out_act && m_tready;
   assign m_tlast    = m_tvalid && w_out_last;
   assign w_out_beat = m_tvalid && m_tready;

   ty_beat_counter #(.W(LENW)) u_in_counter (
      .i_clk      (aclk),
      .i_rst_n    (areset_n),
      .i_clr      (w_start_ok),
      .i_inc      (w_in_beat),
      .i_limit    (r_len_q),
      .o_count    (w_in_cnt),
      .o_hit_next (w_in_last)
   );

   ty_beat_counter #(.W(LENW)) u_out_counter (
      .i_clk      (aclk),
      .i_rst_n    (areset_n),
      .i_clr      (w_start_ok),
      .i_inc      (w_out_beat),
      .i_limit    (r_len_q),
      .o_count    (w_out_cnt),
      .o_hit_next (w_out_last)
   );

   // The final output beat wins over the final input beat so a zero-latency
   // kernel goes straight from RUN to DONE.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_state     <= IDLE;
         r_len_q     <= '0;
         r_done      <= 1'b0;
         r_err_extra <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_len_q     <= len;
                  r_err_extra <= 1'b0;
                  if (len == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_out_beat && w_out_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else if (w_in_beat && w_in_last) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_out_beat && w_out_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
         if (((r_state == IDLE) || (r_state == DONE)) && k_ovalid) begin
            r_err_extra <= 1'b1;
         end
      end
   end

   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign err_extra = r_err_extra;
   assign in_cnt    = w_in_cnt;
   assign out_cnt   = w_out_cnt;

endmodule

// File: tb/tb_ty_stream_run_ctrl.sv
// Scoreboard bench for ty_stream_run_ctrl with a fixed-latency kernel model.
module tb_ty_stream_run_ctrl;
   import ty_ctrl_pkg::*;

   localparam int NCH = 2;
   localparam int LAT = 3;

   logic            aclk     = 1'b0;
   logic            areset_n = 1'b0;
   logic            start    = 1'b0;
   run_len_t        len      = '0;
   logic            busy, done, err_extra;
   run_len_t        in_cnt, out_cnt;
   logic [NCH-1:0]  s_tvalid = '0;
   logic [NCH-1:0]  s_tready;
   logic            k_ivalid;
   logic            k_iready = 1'b1;
   logic            k_ovalid;
   logic            k_oready;
   logic            m_tvalid;
   logic            m_tready = 1'b1;
   logic            m_tlast;
   logic            spur       = 1'b0;
   logic            kHeadReady = 1'b0;

   typedef struct {
      logic last;
      int   cnt;
   } outExp_t;

   outExp_t expOut[$];
   int      expDone[$];
   int      total      = 0;
   int      bad        = 0;
   int      ncyc       = 0;
   int      lastOutCyc = -10;
   int      inBeats    = 0;
   int      doneSeen   = 0;

   assign k_ovalid = spur | kHeadReady;

   ty_stream_run_ctrl #(.C_NUM_CHANNELS(NCH), .LENW(TY_LENW)) dut (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .err_extra (err_extra),
      .in_cnt    (in_cnt),
      .out_cnt   (out_cnt),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .k_ivalid  (k_ivalid),
      .k_iready  (k_iready),
      .k_ovalid  (k_ovalid),
      .k_oready  (k_oready),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out waiting for done", name);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Issues a start and loads the scoreboard with the beats the run must produce.
   task automatic applyStimulus(input int L);
      outExp_t e;
      start = 1'b1;
      len   = run_len_t'(L);
      for (int i = 0; i < L; i++) begin
         e.last = (i == L - 1);
         e.cnt  = i;
         expOut.push_back(e);
      end
      expDone.push_back(L);
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (done !== 1'b1 && n < budget);
      if (done !== 1'b1) reportTimeout(name);
   endtask

   // Kernel model: fixed latency FIFO of beats, flushed by reset.
   initial begin
      int kq[$];
      forever begin
         logic inF, outF;
         @(negedge aclk);
         inF  = k_ivalid & k_iready;
         outF = k_ovalid & k_oready;
         @(posedge aclk);
         #1;
         if (!areset_n) begin
            kq.delete();
         end else begin
            if (outF && kHeadReady) void'(kq.pop_front());
            if (inF) kq.push_back(ncyc + LAT - 1);
         end
         kHeadReady = (kq.size() > 0) && (kq[0] <= ncyc);
      end
   end

   // Monitor: pops the scoreboard on every output beat and on every done.
   initial begin
      forever begin
         @(negedge aclk);
         ncyc++;
         if (areset_n) begin
            if (k_ivalid && k_iready) inBeats++;
            if (m_tvalid) begin
               if (expOut.size() == 0) begin
                  checkOutput("unexpected_out", k_oready, 0);
               end else begin
                  checkOutput("tlast", m_tlast, expOut[0].last);
                  if (m_tready) begin
                     checkOutput("out_cnt_at_beat", out_cnt, expOut[0].cnt);
                     if (expOut[0].last) lastOutCyc = ncyc;
                     void'(expOut.pop_front());
                  end
               end
            end
            if (done) begin
               doneSeen++;
               if (expDone.size() == 0) begin
                  checkOutput("unexpected_done", done, 0);
               end else begin
                  if (expDone[0] > 0) begin
                     checkOutput("done_timing", ncyc, lastOutCyc + 1);
                     checkOutput("final_in_cnt", in_cnt, expDone[0]);
                     checkOutput("final_out_cnt", out_cnt, expDone[0]);
                  end
                  void'(expDone.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic gotDone;

      // Reset state with live inputs that must all be masked.
      s_tvalid = 2'b11;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err_extra, 0);
      checkOutput("rst_in_cnt", in_cnt, 0);
      checkOutput("rst_out_cnt", out_cnt, 0);
      checkOutput("rst_s_tready", s_tready, 0);
      checkOutput("rst_k_ivalid", k_ivalid, 0);
      checkOutput("rst_k_oready", k_oready, 0);
      #1 areset_n = 1'b1;
      tick();

      $display("[TB] run len=4, latency kernel, no backpressure");
      inBeats = 0;
      applyStimulus(4);
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         checkOutput("t1_s_tready", s_tready, 2'b11);
      end
      waitDone("t1_done", 50);
      checkOutput("t1_in_beats", inBeats, 4);
      tick();
      @(negedge aclk);
      checkOutput("t1_busy_fall", busy, 0);
      checkOutput("t1_done_count", doneSeen, 1);

      $display("[TB] channel skew, len=2");
      tick();
      inBeats  = 0;
      s_tvalid = 2'b01;
      applyStimulus(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         checkOutput("t2_skew_s_tready", s_tready, 2'b00);
         checkOutput("t2_skew_k_ivalid", k_ivalid, 0);
      end
      tick();
      s_tvalid = 2'b11;
      @(negedge aclk);
      checkOutput("t2_first_k_ivalid", k_ivalid, 1);
      checkOutput("t2_first_s_tready", s_tready, 2'b11);
      waitDone("t2_done", 50);
      checkOutput("t2_in_beats", inBeats, 2);

      $display("[TB] backpressure, len=3");
      tick();
      applyStimulus(3);
      gotDone = 1'b0;
      for (int i = 0; i < 64 && !gotDone; i++) begin
         m_tready = (i % 2 == 0);
         @(negedge aclk);
         if (i < 4) checkOutput("t3_k_oready", k_oready, m_tready);
         if (done === 1'b1) gotDone = 1'b1;
         else tick();
      end
      if (!gotDone) reportTimeout("t3_done");
      tick();
      m_tready = 1'b1;

      $display("[TB] zero-length run and spurious kernel output");
      start = 1'b1;
      len   = '0;
      expDone.push_back(0);
      tick();
      start = 1'b0;
      @(negedge aclk);
      checkOutput("t4_busy", busy, 1);
      checkOutput("t4_done", done, 1);
      checkOutput("t4_s_tready", s_tready, 0);
      checkOutput("t4_m_tvalid", m_tvalid, 0);
      tick();
      @(negedge aclk);
      checkOutput("t4_busy_after", busy, 0);
      checkOutput("t4_done_after", done, 0);
      tick();
      spur = 1'b1;
      @(negedge aclk);
      checkOutput("t4_spur_m_tvalid", m_tvalid, 0);
      checkOutput("t4_spur_k_oready", k_oready, 0);
      tick();
      spur = 1'b0;
      @(negedge aclk);
      checkOutput("t4_err_set", err_extra, 1);
      tick();
      @(negedge aclk);
      checkOutput("t4_err_sticky", err_extra, 1);

      $display("[TB] overrun, len=2, start ignored while running");
      tick();
      inBeats = 0;
      applyStimulus(2);
      start = 1'b1;
      len   = run_len_t'(7);
      @(negedge aclk);
      checkOutput("t5_err_cleared", err_extra, 0);
      checkOutput("t5_busy", busy, 1);
      tick();
      start = 1'b0;
      len   = '0;
      @(negedge aclk);
      tick();
      @(negedge aclk);
      checkOutput("t5_drain_s_tready", s_tready, 2'b00);
      checkOutput("t5_drain_in_cnt", in_cnt, 2);
      waitDone("t5_done", 50);
      checkOutput("t5_in_beats", inBeats, 2);
      checkOutput("sb_out_empty", expOut.size(), 0);
      checkOutput("sb_done_empty", expDone.size(), 0);

      $display("[TB] reset in the middle of a run, len=5");
      tick();
      applyStimulus(5);
      tick();
      tick();
      s_tvalid = 2'b00;
      @(negedge aclk);
      checkOutput("t6_pre_in_cnt", in_cnt, 2);
      #2;
      s_tvalid = 2'b11;
      areset_n = 1'b0;
      expOut.delete();
      expDone.delete();
      #1;
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_in_cnt", in_cnt, 0);
      checkOutput("t6_out_cnt", out_cnt, 0);
      checkOutput("t6_s_tready", s_tready, 0);
      checkOutput("t6_done", done, 0);
      @(negedge aclk);
      #1 areset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         checkOutput("t6_no_done", done, 0);
         checkOutput("t6_idle", busy, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
